instr_encoder: RTL and testbench

Pipelined RISC-V instruction encoder; the inverse of the `id` decode stage. Accepts decoded fields (opcode, rd, rs1, rs2, func3, func7, imm) over a valid/ready handshake and emits the 32-bit instruction word. Handles all eleven opcodes the decoder recognises. Flags unsupported opcodes and out-of-range immediates. Used as a stimulus/reference generator for decoder benches and as the back end of a future assembler path.

---
 rtl/instr_encoder.sv | 173 +++++++++++++++++
 tb/tb_instr_encoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Two-stage RISC-V instruction encoder: turns decoded fields back into a 32-bit word.
// Unsupported opcodes produce a NOP with out_err set; out-of-range immediates set out_err.
module instr_encoder #(
    parameter int INSTRUCTON_WIDTH = 32,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [6:0]                  opcode,
    input  logic [4:0]                  rd,
    input  logic [4:0]                  rs1,
    input  logic [4:0]                  rs2,
    input  logic [2:0]                  func3,
    input  logic [6:0]                  func7,
    input  logic [31:0]                 imm,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INSTRUCTON_WIDTH-1:0] out_instr,
    output logic                        out_err,
    output logic [CNT_WIDTH-1:0]        enc_count,
    output logic [CNT_WIDTH-1:0]        err_count
);

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SHIFT, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } InstrFormat;

    InstrFormat w_fmt;
    InstrFormat r_s1_fmt;
    logic       r_s1_valid;
    logic [6:0] r_s1_opcode;
    logic [4:0] r_s1_rd;
    logic [4:0] r_s1_rs1;
    logic [4:0] r_s1_rs2;
    logic [2:0] r_s1_func3;
    logic [6:0] r_s1_func7;
    logic [31:0] r_s1_imm;

    logic                        r_s2_valid;
    logic [INSTRUCTON_WIDTH-1:0] r_s2_instr;
    logic                        r_s2_err;
    logic [CNT_WIDTH-1:0]        r_enc_count;
    logic [CNT_WIDTH-1:0]        r_err_count;

    logic                        w_accept;
    logic                        w_s1_adv;
    logic                        w_out_fire;
    logic [INSTRUCTON_WIDTH-1:0] w_word;
    logic                        w_err;

    assign w_out_fire = r_s2_valid && out_ready;
    assign w_s1_adv   = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready   = !r_s1_valid || !r_s2_valid || out_ready;
    assign w_accept   = in_valid && in_ready;

    always_comb begin
        w_fmt = FMT_BAD;
        case (opcode)
            7'b0110011, 7'b0101111: w_fmt = FMT_R;
            7'b0010011:             w_fmt = (func3 == 3'b001 || func3 == 3'b101) ? FMT_SHIFT : FMT_I;
            7'b0000011, 7'b1100111,
            7'b1110011:             w_fmt = FMT_I;
            7'b0100011:             w_fmt = FMT_S;
            7'b1100011:             w_fmt = FMT_B;
            7'b1101111:             w_fmt = FMT_J;
            7'b0010111, 7'b0110111: w_fmt = FMT_U;
            default:                w_fmt = FMT_BAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_fmt    <= FMT_BAD;
            r_s1_opcode <= '0;
            r_s1_rd     <= '0;
            r_s1_rs1    <= '0;
            r_s1_rs2    <= '0;
            r_s1_func3  <= '0;
            r_s1_func7  <= '0;
            r_s1_imm    <= '0;
        end else if (w_accept) begin
            r_s1_valid  <= 1'b1;
            r_s1_fmt    <= w_fmt;
            r_s1_opcode <= opcode;
            r_s1_rd     <= rd;
            r_s1_rs1    <= rs1;
            r_s1_rs2    <= rs2;
            r_s1_func3  <= func3;
            r_s1_func7  <= func7;
            r_s1_imm    <= imm;
        end else if (w_s1_adv) begin
            r_s1_valid  <= 1'b0;
        end
    end

    // Range checks: a sign-extended immediate must have all bits above its top field bit equal.
    always_comb begin
        w_word = 32'h0000_0013;
        w_err  = 1'b1;
        case (r_s1_fmt)
            FMT_R: begin
                w_word = {r_s1_func7, r_s1_rs2, r_s1_rs1, r_s1_func3, r_s1_rd, r_s1_opcode};
                w_err  = 1'b0;
            end
            FMT_I: begin
                w_word = {r_s1_imm[11:0], r_s1_rs1, r_s1_func3, r_s1_rd, r_s1_opcode};
                w_err  = !((&r_s1_imm[31:11]) || !(|r_s1_imm[31:11]));
            end
            FMT_SHIFT: begin
                w_word = {r_s1_func7, r_s1_imm[4:0], r_s1_rs1, r_s1_func3, r_s1_rd, r_s1_opcode};
                w_err  = |r_s1_imm[31:5];
            end
            FMT_S: begin
                w_word = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_func3, r_s1_imm[4:0], r_s1_opcode};
                w_err  = !((&r_s1_imm[31:11]) || !(|r_s1_imm[31:11]));
            end
            FMT_B: begin
                w_word = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_func3,
                          r_s1_imm[4:1], r_s1_imm[11], r_s1_opcode};
                w_err  = !((&r_s1_imm[31:12]) || !(|r_s1_imm[31:12])) || r_s1_imm[0];
            end
            FMT_U: begin
                w_word = {r_s1_imm[31:12], r_s1_rd, r_s1_opcode};
                w_err  = |r_s1_imm[11:0];
            end
            FMT_J: begin
                w_word = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                          r_s1_rd, r_s1_opcode};
                w_err  = !((&r_s1_imm[31:20]) || !(|r_s1_imm[31:20])) || r_s1_imm[0];
            end
            default: begin
                w_word = 32'h0000_0013;
                w_err  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_instr <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= 1'b1;
            r_s2_instr <= w_word;
            r_s2_err   <= w_err;
        end else if (w_out_fire) begin
            r_s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enc_count <= '0;
            r_err_count <= '0;
        end else if (w_out_fire) begin
            r_enc_count <= r_enc_count + CNT_WIDTH'(1);
            if (r_s2_err) begin
                r_err_count <= r_err_count + CNT_WIDTH'(1);
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_instr = r_s2_instr;
    assign out_err   = r_s2_err;
    assign enc_count = r_enc_count;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected words are queued when a field set is
// accepted and compared when the matching output handshake happens.
module tb_instr_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } ExpEntry;

    ExpEntry expQ[$];
    int checkCount = 0;
    int passCount  = 0;
    int modelEnc   = 0;
    int modelErr   = 0;

    instr_encoder #(.INSTRUCTON_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .func3     (func3),
        .func7     (func7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    task automatic setFields(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                             input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [31:0] im);
        opcode = op; rd = d; rs1 = s1; rs2 = s2; func3 = f3; func7 = f7; imm = im;
    endtask

    // Offers one field set and returns #1 after the edge that captured it.
    task automatic applyStimulus(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] im, input logic [31:0] expInstr, input logic expErr);
        bit accepted = 0;
        setFields(op, d, s1, s2, f3, f7, im);
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (in_ready) begin
                expQ.push_back('{instr: expInstr, err: expErr});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                accepted = 1;
                break;
            end
        end
        if (!accepted) begin
            in_valid = 1'b0;
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        end
    endtask

    task automatic waitDrain();
        bit drained = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !out_valid) begin
                drained = 1;
                break;
            end
        end
        if (!drained) checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                ExpEntry e;
                e = expQ.pop_front();
                checkOutput("out_instr", out_instr, e.instr);
                checkOutput("out_err", 32'(out_err), 32'(e.err));
                modelEnc++;
                if (e.err) modelErr++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        setFields(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_instr", out_instr, 32'd0);
        checkOutput("reset_out_err", 32'(out_err), 32'd0);
        checkOutput("reset_enc_count", 32'(enc_count), 32'd0);
        checkOutput("reset_err_count", 32'(err_count), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // addi x1,x2,5 with a latency check: S1 after the capture edge, S2 one edge later.
        applyStimulus(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0051_0093, 1'b0);
        checkOutput("latency_s1_only", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("latency_s2_valid", 32'(out_valid), 32'd1);
        applyStimulus(7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8, 32'h0051_2423, 1'b0);
        applyStimulus(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
        applyStimulus(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
        applyStimulus(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        applyStimulus(7'b1111111, 5'd3, 5'd4, 5'd5, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1);
        applyStimulus(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h8001_0093, 1'b1);
        applyStimulus(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_81B3, 1'b0);
        applyStimulus(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd3, 32'h0030_9093, 1'b0);
        applyStimulus(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd32, 32'h0000_9093, 1'b1);
        applyStimulus(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 32'h0000_0363, 1'b0);
        applyStimulus(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0000_0263, 1'b1);
        applyStimulus(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1);
        waitDrain();
        checkOutput("enc_count_directed", 32'(enc_count), 32'(modelEnc));
        checkOutput("err_count_directed", 32'(err_count), 32'(modelErr));
        checkOutput("err_count_literal", 32'(err_count), 32'd5);

        // Backpressure: two entries fill both stages, the third must wait.
        rst = 1'b1; #1; rst = 1'b0;
        expQ.delete(); modelEnc = 0; modelErr = 0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0051_0093, 1'b0);
        applyStimulus(7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8, 32'h0051_2423, 1'b0);
        setFields(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_instr_stable", out_instr, 32'h0051_0093);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
        expQ.push_back('{instr: 32'h1234_52B7, err: 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        waitDrain();
        checkOutput("bp_enc_count", 32'(enc_count), 32'd3);
        checkOutput("bp_err_count", 32'(err_count), 32'd0);

        // Reset with both stages full: everything is discarded at once.
        @(posedge clk); #1;
        out_ready = 1'b0;
        applyStimulus(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
        applyStimulus(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1);
        @(negedge clk);
        checkOutput("full_in_ready_low", 32'(in_ready), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_enc_count", 32'(enc_count), 32'd0);
        checkOutput("async_err_count", 32'(err_count), 32'd0);
        checkOutput("async_out_instr", out_instr, 32'd0);
        expQ.delete(); modelEnc = 0; modelErr = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("no_stale_out_valid", 32'(out_valid), 32'd0);
            checkOutput("post_reset_ready", 32'(in_ready), 32'd1);
        end
        checkOutput("post_reset_enc_count", 32'(enc_count), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
